// File: rtl/spi_accel_responder.sv
// SPI mode-0 accelerometer register responder: ID, X/Y/Z samples, 16 scratch bytes.
// Latency: SYNC_STAGES+1 clk from any pin change to internal reaction; miso follows sclk fall by about the same.
// Backpressure: none; SPI master paces every transfer, sample_valid during a transaction is held pending.
// Optional: define SPI_RESP_STATUS_EN to expose a data_ready status bit at address 0x0B.
`timescale 1ns/1ps
module spi_accel_responder #(
   parameter int SYNC_STAGES = 2   // must be >= 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   input  logic [11:0] sample_x,
   input  logic [11:0] sample_y,
   input  logic [11:0] sample_z,
   input  logic        sample_valid,
   output logic [7:0]  power_ctl,
   output logic        reg_wr_strobe,
   output logic [5:0]  reg_wr_addr,
   output logic [7:0]  reg_wr_data,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] ADDR = 2'd2;
   localparam logic [1:0] DATA = 2'd3;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   // The chip-select chain resets to "selected" (0) so that a cs_n held low
   // across reset never looks like a fresh falling edge; only a real high
   // period followed by a new fall starts a transaction.
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
   logic       sclk_prev, cs_prev;
   logic       sclk_s, cs_s, mosi_s;
   logic       sclk_rise, sclk_fall, cs_fall;

   logic [1:0]  state;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_in;
   logic [7:0]  rx_byte;
   logic [7:0]  cmd;
   logic [5:0]  addr;
   logic [7:0]  shift_out;
   logic        load_pend;
   logic [7:0]  rd_data;
   logic [7:0]  scratch [16];

   logic [11:0] samp_x, samp_y, samp_z;
   logic [11:0] pend_x, pend_y, pend_z;
   logic        pend_flag;
`ifdef SPI_RESP_STATUS_EN
   logic        data_ready;
   logic        rd_clear;
`endif

   // Bring the SPI pins into the clk domain and remember last synced levels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = cs_prev & ~cs_s;
   assign rx_byte   = {shift_in, mosi_s};

   assign busy      = (state != IDLE);
   // The responder only owns the line while a selected transaction is live.
   assign miso_oe   = (state != IDLE);
   assign power_ctl = scratch[4'hD];

   // Read mux over the register map; sample registers are the frozen snapshot.
   always_comb begin
      rd_data = 8'h00;
      case (addr)
         6'h00: rd_data = 8'hAD;
         6'h01: rd_data = 8'h1D;
         6'h02: rd_data = 8'hF2;
`ifdef SPI_RESP_STATUS_EN
         6'h0B: rd_data = {7'b0, data_ready};
`endif
         6'h0E: rd_data = samp_x[7:0];
         6'h0F: rd_data = {{4{samp_x[11]}}, samp_x[11:8]};
         6'h10: rd_data = samp_y[7:0];
         6'h11: rd_data = {{4{samp_y[11]}}, samp_y[11:8]};
         6'h12: rd_data = samp_z[7:0];
         6'h13: rd_data = {{4{samp_z[11]}}, samp_z[11:8]};
         default: if (addr[5:4] == 2'b10) rd_data = scratch[addr[3:0]];
      endcase
   end

   // Transaction FSM: bit capture, command/address decode, writes and miso shifting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bit_cnt       <= 3'd0;
         shift_in      <= 7'd0;
         cmd           <= 8'h00;
         addr          <= 6'd0;
         shift_out     <= 8'h00;
         load_pend     <= 1'b0;
         miso          <= 1'b0;
         reg_wr_strobe <= 1'b0;
         reg_wr_addr   <= 6'd0;
         reg_wr_data   <= 8'h00;
         for (int i = 0; i < 16; i++) scratch[i] <= 8'h00;
      end else begin
         reg_wr_strobe <= 1'b0;
         if (cs_s) begin
            // Deselect aborts everything, including a partially shifted byte.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
            miso      <= 1'b0;
         end else begin
            if (state != IDLE && sclk_rise) begin
               shift_in <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state   <= CMD;
                     bit_cnt <= 3'd0;
                  end
               end
               CMD: begin
                  if (sclk_rise && bit_cnt == 3'd7) begin
                     cmd   <= rx_byte;
                     state <= ADDR;
                  end
               end
               ADDR: begin
                  if (sclk_rise && bit_cnt == 3'd7) begin
                     addr      <= rx_byte[5:0];
                     state     <= DATA;
                     load_pend <= (cmd == CMD_READ);
                  end
               end
               default: begin
                  if (sclk_rise && bit_cnt == 3'd7) begin
                     if (cmd == CMD_WRITE && addr[5:4] == 2'b10) begin
                        scratch[addr[3:0]] <= rx_byte;
                        reg_wr_strobe      <= 1'b1;
                        reg_wr_addr        <= addr;
                        reg_wr_data        <= rx_byte;
                     end
                     addr      <= addr + 6'd1;
                     load_pend <= (cmd == CMD_READ);
                  end else if (sclk_fall && cmd == CMD_READ) begin
                     if (load_pend) begin
                        miso      <= rd_data[7];
                        shift_out <= {rd_data[6:0], 1'b0};
                        load_pend <= 1'b0;
                     end else begin
                        miso      <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                     end
                  end
               end
            endcase
         end
      end
   end

`ifdef SPI_RESP_STATUS_EN
   assign rd_clear = (state == DATA) && !cs_s && sclk_fall && (cmd == CMD_READ) &&
                     load_pend && (addr == 6'h0E);
`endif

   // Sample capture: live while deselected, deferred to deselect while a transaction runs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_x    <= 12'd0;
         samp_y    <= 12'd0;
         samp_z    <= 12'd0;
         pend_x    <= 12'd0;
         pend_y    <= 12'd0;
         pend_z    <= 12'd0;
         pend_flag <= 1'b0;
`ifdef SPI_RESP_STATUS_EN
         data_ready <= 1'b0;
`endif
      end else begin
         if (cs_s) begin
            if (sample_valid) begin
               samp_x <= sample_x;
               samp_y <= sample_y;
               samp_z <= sample_z;
            end else if (pend_flag) begin
               samp_x <= pend_x;
               samp_y <= pend_y;
               samp_z <= pend_z;
            end
            pend_flag <= 1'b0;
`ifdef SPI_RESP_STATUS_EN
            if (sample_valid || pend_flag) data_ready <= 1'b1;
`endif
         end else begin
            if (sample_valid) begin
               pend_x    <= sample_x;
               pend_y    <= sample_y;
               pend_z    <= sample_z;
               pend_flag <= 1'b1;
            end
`ifdef SPI_RESP_STATUS_EN
            if (rd_clear) data_ready <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench for spi_accel_responder: stimulus pushes expected miso bytes
// and expected register writes; two monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_accel_responder;

   logic        clk = 1'b0;
   logic        reset, sclk, cs_n, mosi;
   logic        miso, miso_oe, busy;
   logic [11:0] sample_x, sample_y, sample_z;
   logic        sample_valid;
   logic [7:0]  power_ctl;
   logic        reg_wr_strobe;
   logic [5:0]  reg_wr_addr;
   logic [7:0]  reg_wr_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_rd [$];
   logic [13:0] exp_wr [$];

   spi_accel_responder #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
      .sample_valid(sample_valid), .power_ctl(power_ctl),
      .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // miso monitor: assembles one byte per 8 sclk rising edges while selected.
   initial begin : rd_mon
      int bitc;
      logic [7:0] sh;
      bitc = 0;
      sh   = 8'h00;
      forever begin
         @(posedge sclk or posedge cs_n or posedge reset);
         if (cs_n === 1'b1 || reset === 1'b1) begin
            bitc = 0;
         end else begin
            sh = {sh[6:0], miso};
            bitc++;
            if (bitc == 8) begin
               bitc = 0;
               if (exp_rd.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL miso_byte: got 0x%0h with no byte expected", sh);
               end else begin
                  chk("miso_byte", {24'd0, sh}, {24'd0, exp_rd.pop_front()});
               end
            end
         end
      end
   end

   // Write-strobe monitor: every strobed cycle must match the next expected write.
   always @(negedge clk) begin
      if (reset === 1'b0 && reg_wr_strobe === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_strobe: got addr 0x%0h data 0x%0h with no write expected",
                     reg_wr_addr, reg_wr_data);
         end else begin
            chk("wr_strobe", {18'd0, reg_wr_addr, reg_wr_data}, {18'd0, exp_wr.pop_front()});
         end
      end
   end

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         #50 sclk = 1'b1;
         #50 sclk = 1'b0;
      end
   endtask

   task automatic tx(input logic [7:0] b, input logic [7:0] e);
      exp_rd.push_back(e);
      send_bits(b, 8);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #100 cs_n = 1'b1;
      #300;
   endtask

   task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
      sample_x = x;
      sample_y = y;
      sample_z = z;
      sample_valid = 1'b1;
      #10 sample_valid = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      sample_x = 12'd0; sample_y = 12'd0; sample_z = 12'd0; sample_valid = 1'b0;
      #50;
      chk("reset_miso", miso, 0);
      chk("reset_miso_oe", miso_oe, 0);
      chk("reset_busy", busy, 0);
      chk("reset_strobe", reg_wr_strobe, 0);
      chk("reset_wr_addr", reg_wr_addr, 0);
      chk("reset_wr_data", reg_wr_data, 0);
      chk("reset_power_ctl", power_ctl, 0);
      #10 reset = 1'b0;
      #100;
      chk("idle_busy", busy, 0);

      // Device ID burst
      cs_low();
      chk("busy_selected", busy, 1);
      chk("miso_oe_selected", miso_oe, 1);
      tx(8'h0B, 8'h00); tx(8'h00, 8'h00);
      tx(8'h00, 8'hAD); tx(8'h00, 8'h1D); tx(8'h00, 8'hF2);
      cs_high();
      chk("busy_deselected", busy, 0);
      chk("miso_oe_deselected", miso_oe, 0);
      chk("miso_deselected", miso, 0);

      // Write power_ctl then read it back
      exp_wr.push_back({6'h2D, 8'h02});
      cs_low(); tx(8'h0A, 8'h00); tx(8'h2D, 8'h00); tx(8'h02, 8'h00); cs_high();
      chk("power_ctl_after_write", power_ctl, 8'h02);
      cs_low(); tx(8'h0B, 8'h00); tx(8'h2D, 8'h00); tx(8'h00, 8'h02); cs_high();

      // Samples: coherent burst while a new sample arrives mid-transaction
      pulse_sample(12'hFFB, 12'h000, 12'h000);
      #100;
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0E, 8'h00); tx(8'h00, 8'hFB);
      pulse_sample(12'h001, 12'h7A5, 12'h800);
      tx(8'h00, 8'hFF); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0E, 8'h00);
      tx(8'h00, 8'h01); tx(8'h00, 8'h00); tx(8'h00, 8'hA5);
      tx(8'h00, 8'h07); tx(8'h00, 8'h00); tx(8'h00, 8'hF8);
      cs_high();

      // Abort a write after 5 data bits
      cs_low(); tx(8'h0A, 8'h00); tx(8'h21, 8'h00); send_bits(8'hFF, 5); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h00, 8'h00); tx(8'h00, 8'hAD); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h21, 8'h00); tx(8'h00, 8'h00); cs_high();

      // Address wrap on read
      cs_low(); tx(8'h0B, 8'h00); tx(8'h3F, 8'h00); tx(8'h00, 8'h00); tx(8'h00, 8'hAD); cs_high();

      // Unknown command: nothing driven, nothing written
      cs_low(); tx(8'h55, 8'h00); tx(8'h2D, 8'h00); tx(8'hFF, 8'h00); tx(8'hFF, 8'h00); cs_high();
      chk("power_ctl_after_invalid", power_ctl, 8'h02);

      // Write bursts: auto-increment, and discard past the scratch window
      exp_wr.push_back({6'h20, 8'h11});
      exp_wr.push_back({6'h21, 8'h22});
      cs_low(); tx(8'h0A, 8'h00); tx(8'h20, 8'h00); tx(8'h11, 8'h00); tx(8'h22, 8'h00); cs_high();
      exp_wr.push_back({6'h2F, 8'hA5});
      cs_low(); tx(8'h0A, 8'h00); tx(8'h2F, 8'h00); tx(8'hA5, 8'h00); tx(8'h5A, 8'h00); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h2F, 8'h00); tx(8'h00, 8'hA5); tx(8'h00, 8'h00); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h20, 8'h00); tx(8'h00, 8'h11); tx(8'h00, 8'h22); cs_high();

      // Reset in the middle of a write; cs_n stays low through and after reset
      cs_low(); tx(8'h0A, 8'h00); tx(8'h2D, 8'h00);
      #30 reset = 1'b1;
      #20;
      chk("midreset_power_ctl", power_ctl, 8'h00);
      chk("midreset_busy", busy, 0);
      chk("midreset_miso", miso, 0);
      reset = 1'b0;
      #100;
      tx(8'h55, 8'h00); tx(8'h55, 8'h00);
      chk("post_reset_not_busy", busy, 0);
      cs_high();
      chk("post_reset_power_ctl", power_ctl, 8'h00);
      cs_low(); tx(8'h0B, 8'h00); tx(8'h01, 8'h00); tx(8'h00, 8'h1D); cs_high();

      // Status register at 0x0B
      pulse_sample(12'h001, 12'h000, 12'h000);
      #100;
`ifdef SPI_RESP_STATUS_EN
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0B, 8'h00); tx(8'h00, 8'h01); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0E, 8'h00); tx(8'h00, 8'h01); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0B, 8'h00); tx(8'h00, 8'h00); cs_high();
`else
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0B, 8'h00); tx(8'h00, 8'h00); cs_high();
      cs_low(); tx(8'h0B, 8'h00); tx(8'h0E, 8'h00); tx(8'h00, 8'h01); cs_high();
`endif

      #200;
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("wr_queue_drained", exp_wr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
